// File: rtl/mem_ctrl_multi_pkg.sv
// Shared definitions for the multi-channel memory controller.
//   chan_state_e : per-channel receive FSM encoding (IDLE/RECV/WAIT/BUSY)
//   STATE_W      : width of one channel state
//   cov_sum_w()  : width of the coverage counter for a given channel count
package mem_ctrl_multi_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2,
    BUSY = 2'd3
  } chan_state_e;

  // One extra bit so a fully covered map (2^(2*nch) entries) does not wrap.
  function automatic int cov_sum_w(input int nch);
    return STATE_W * nch + 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_multi_if.sv
// Beat input / word output bundle of the multi-channel memory controller.
//   in_valid  : per-channel beat valid            (master -> slave)
//   in_data   : per-channel beats, ch c at [c*BEAT_W +: BEAT_W]
//   in_ready  : per-channel ready                 (slave -> master)
//   out_valid : a word is presented this cycle
//   out_data  : presented word, 0 when idle
//   out_ch    : source channel of the word, 0 when idle
interface mem_ctrl_multi_if #(
  parameter int NCH    = 3,
  parameter int BEAT_W = 2,
  parameter int BEATS  = 2
);
  localparam int DW = BEAT_W * BEATS;

  logic [NCH-1:0]        in_valid;
  logic [NCH*BEAT_W-1:0] in_data;
  logic [NCH-1:0]        in_ready;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic [1:0]            out_ch;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mem_ctrl_multi_chan.sv
// Single receive channel: assembles BEATS beats into a word, waits for a
// grant, then presents the word for exactly one BUSY cycle.
//   clock, reset : clock and synchronous active-high reset
//   i_grant      : arbiter grant (only honoured in WAIT)
//   i_valid      : beat valid
//   i_beat       : beat data
//   o_state      : current FSM state
//   o_data       : assembled word register
//   o_ready      : high in IDLE and RECV
module mem_ctrl_chan
  import mem_ctrl_multi_pkg::*;
#(
  parameter int BEAT_W = 2,
  parameter int BEATS  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_grant,
  input  logic                      i_valid,
  input  logic [BEAT_W-1:0]         i_beat,
  output chan_state_e               o_state,
  output logic [BEAT_W*BEATS-1:0]   o_data,
  output logic                      o_ready
);

  localparam int DW    = BEAT_W * BEATS;
  localparam int CNT_W = $clog2(BEATS);

  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_data;
  logic             r_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_state <= RECV;
            r_data  <= DW'(i_beat);
            r_cnt   <= CNT_W'(1);
          end
        end
        RECV: begin
          if (i_valid) begin
            for (int b = 1; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) r_data[b*BEAT_W +: BEAT_W] <= i_beat;
            end
            if (r_cnt == CNT_W'(BEATS - 1)) begin
              r_state <= WAIT;
              r_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            // Aborted word: data left stale, never presented.
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (i_grant) r_state <= BUSY;
        end
        BUSY: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;
  assign o_ready = r_ready;

endmodule

// File: rtl/mem_ctrl_multi.sv
// NCH-channel memory controller: per-channel receive FSMs, a round-robin
// arbiter onto one output, and a state-vector coverage counter.
//   clock, reset : clock and synchronous active-high reset (channels, arbiter)
//   meta_reset   : synchronous active-high clear of coverage state only
//   bus          : beat inputs and word output (slave side)
//   coverage     : distinct channel-state vectors seen
//   io_cov_sum   : same value as coverage
//   bug          : all channels in WAIT at once
module mem_ctrl_multi
  import mem_ctrl_multi_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int BEAT_W = 2,
  parameter int BEATS  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         meta_reset,
  mem_ctrl_multi_if.slave              bus,
  output logic [cov_sum_w(NCH)-1:0]    coverage,
  output logic [cov_sum_w(NCH)-1:0]    io_cov_sum,
  output logic                         bug
);

  localparam int DW      = BEAT_W * BEATS;
  localparam int COV_W   = cov_sum_w(NCH);
  localparam int VEC_W   = STATE_W * NCH;
  localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MAP_N   = 2 ** VEC_W;

  chan_state_e      w_state [NCH];
  logic [DW-1:0]    w_data  [NCH];
  logic [NCH-1:0]   w_ready;
  logic [NCH-1:0]   w_grant;
  logic [VEC_W-1:0] w_state_vec;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    mem_ctrl_chan #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .i_grant (w_grant[c]),
      .i_valid (bus.in_valid[c]),
      .i_beat  (bus.in_data[c*BEAT_W +: BEAT_W]),
      .o_state (w_state[c]),
      .o_data  (w_data[c]),
      .o_ready (w_ready[c])
    );
    assign w_state_vec[c*STATE_W +: STATE_W] = w_state[c];
  end

  assign bus.in_ready = w_ready;

  // Round-robin arbiter: first WAIT channel at or after the pointer.
  logic [IDX_W-1:0] r_ptr;
  logic             w_grant_any;
  logic [IDX_W-1:0] w_grant_idx;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
    return IDX_W'((int'(ptr) + k) % NCH);
  endfunction

  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_grant_any && (w_state[rr_idx(r_ptr, k)] == WAIT)) begin
        w_grant[rr_idx(r_ptr, k)] = 1'b1;
        w_grant_any               = 1'b1;
        w_grant_idx               = rr_idx(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= (w_grant_idx == IDX_W'(NCH - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // Output mux; at most one channel is BUSY at a time.
  logic          w_out_valid;
  logic [DW-1:0] w_out_data;
  logic [1:0]    w_out_ch;
  logic          w_all_wait;

  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_out_ch    = '0;
    w_all_wait  = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (w_state[c] == BUSY) begin
        w_out_valid = 1'b1;
        w_out_data  = w_data[c];
        w_out_ch    = 2'(c);
      end
      if (w_state[c] != WAIT) w_all_wait = 1'b0;
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_ch    = w_out_ch;
  assign bug           = w_all_wait;

  // Coverage is deliberately outside reset; only meta_reset clears it.
  logic [VEC_W-1:0] r_reg_state = '0;
  logic [MAP_N-1:0] r_covmap    = '0;
  logic [COV_W-1:0] r_covsum    = '0;

  always_ff @(posedge clock) begin
    r_reg_state <= w_state_vec;
    if (meta_reset) begin
      r_covmap <= '0;
      r_covsum <= '0;
    end else if (!r_covmap[r_reg_state]) begin
      r_covmap[r_reg_state] <= 1'b1;
      if (r_covsum != COV_W'(MAP_N)) r_covsum <= r_covsum + 1'b1;
    end
  end

  assign coverage   = r_covsum;
  assign io_cov_sum = r_covsum;

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// Self-checking bench for mem_ctrl_multi (NCH=3, BEAT_W=2, BEATS=2):
// directed scenarios followed by random traffic, all compared against a
// word-level reference model.
module tb_mem_ctrl_multi;

  localparam int NCH    = 3;
  localparam int BEAT_W = 2;
  localparam int BEATS  = 2;
  localparam int DW     = BEAT_W * BEATS;
  localparam int COV_W  = 2 * NCH + 1;
  localparam int MAP_N  = 2 ** (2 * NCH);

  logic clock;
  logic reset;
  logic meta_reset;
  logic [COV_W-1:0] coverage;
  logic [COV_W-1:0] io_cov_sum;
  logic bug;

  mem_ctrl_multi_if #(.NCH(NCH), .BEAT_W(BEAT_W), .BEATS(BEATS)) bus ();

  mem_ctrl_multi #(.NCH(NCH), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clock      (clock),
    .reset      (reset),
    .meta_reset (meta_reset),
    .bus        (bus),
    .coverage   (coverage),
    .io_cov_sum (io_cov_sum),
    .bug        (bug)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. Phase codes: 0 idle, 1 collecting, 2 waiting, 3 presenting.
  int m_phase [NCH];
  int m_got   [NCH];
  int m_word  [NCH];
  int m_ptr;
  bit m_seen  [MAP_N];
  int m_cov;
  int m_prev_vec;
  bit m_cmp_en;

  task automatic model_step(input logic [NCH-1:0] v, input logic [NCH*BEAT_W-1:0] d,
                            input logic rst, input logic mrst);
    int vec;
    int g;
    int beat;
    vec = 0;
    for (int c = 0; c < NCH; c++) vec += m_phase[c] << (2 * c);
    if (mrst) begin
      for (int i = 0; i < MAP_N; i++) m_seen[i] = 1'b0;
      m_cov = 0;
    end else if (!m_seen[m_prev_vec]) begin
      m_seen[m_prev_vec] = 1'b1;
      if (m_cov < MAP_N) m_cov++;
    end
    m_prev_vec = vec;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_phase[c] = 0;
        m_got[c]   = 0;
        m_word[c]  = 0;
      end
      m_ptr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && m_phase[(m_ptr + k) % NCH] == 2) g = (m_ptr + k) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
        beat = int'((d >> (c * BEAT_W)) & ((1 << BEAT_W) - 1));
        if (m_phase[c] == 0) begin
          if (v[c]) begin
            m_word[c]  = beat;
            m_got[c]   = 1;
            m_phase[c] = 1;
          end
        end else if (m_phase[c] == 1) begin
          if (v[c]) begin
            m_word[c] = m_word[c] | (beat << (BEAT_W * m_got[c]));
            m_got[c]++;
            if (m_got[c] == BEATS) m_phase[c] = 2;
          end else begin
            m_phase[c] = 0;
          end
        end else if (m_phase[c] == 2) begin
          if (c == g) m_phase[c] = 3;
        end else begin
          m_phase[c] = 0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % NCH;
    end
  endtask

  task automatic compare_outputs();
    int e_valid;
    int e_data;
    int e_ch;
    int e_ready;
    int e_bug;
    e_valid = 0;
    e_data  = 0;
    e_ch    = 0;
    e_ready = 0;
    e_bug   = 1;
    for (int c = 0; c < NCH; c++) begin
      if (m_phase[c] == 3) begin
        e_valid = 1;
        e_data  = m_word[c];
        e_ch    = c;
      end
      if (m_phase[c] < 2) e_ready |= 1 << c;
      if (m_phase[c] != 2) e_bug = 0;
    end
    check("out_valid", 32'(bus.out_valid), 32'(e_valid));
    check("out_data", 32'(bus.out_data), 32'(e_data));
    check("out_ch", 32'(bus.out_ch), 32'(e_ch));
    check("in_ready", 32'(bus.in_ready), 32'(e_ready));
    check("bug", 32'(bug), 32'(e_bug));
    check("coverage", 32'(coverage), 32'(m_cov));
    check("io_cov_sum", 32'(io_cov_sum), 32'(m_cov));
  endtask

  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH*BEAT_W-1:0] d,
                       input logic rst, input logic mrst);
    bus.in_valid = v;
    bus.in_data  = d;
    reset        = rst;
    meta_reset   = mrst;
    if (m_cmp_en) compare_outputs();
    @(posedge clock);
    model_step(v, d, rst, mrst);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NCH-1:0]        rv;
    logic [NCH*BEAT_W-1:0] rd;
    logic                  rr;
    logic                  rm;
    m_cmp_en   = 1'b0;
    m_ptr      = 0;
    m_cov      = 0;
    m_prev_vec = 0;
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 0;
      m_got[c]   = 0;
      m_word[c]  = 0;
    end
    for (int i = 0; i < MAP_N; i++) m_seen[i] = 1'b0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    reset        = 1'b1;
    meta_reset   = 1'b1;

    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    m_cmp_en = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h7);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    idle(3);
    check("cov_idle", 32'(coverage), 32'd1);

    // Single word on ch0.
    cycle(3'b001, 6'b000001, 1'b0, 1'b0);
    cycle(3'b001, 6'b000010, 1'b0, 1'b0);
    check("single_wait_ready", 32'(bus.in_ready), 32'h6);
    cycle('0, '0, 1'b0, 1'b0);
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_data", 32'(bus.out_data), 32'h9);
    check("single_ch", 32'(bus.out_ch), 32'h0);
    check("single_busy_ready", 32'(bus.in_ready), 32'h6);
    cycle('0, '0, 1'b0, 1'b0);
    check("single_done", 32'(bus.out_valid), 32'h0);
    idle(3);
    check("cov_word", 32'(coverage), 32'd4);

    // Same word again: no new state vectors.
    cycle(3'b001, 6'b000001, 1'b0, 1'b0);
    cycle(3'b001, 6'b000010, 1'b0, 1'b0);
    idle(5);
    check("cov_repeat", 32'(coverage), 32'd4);

    // Abort on ch1, then a good word.
    cycle(3'b010, 6'b001100, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0);
    check("abort_ready", 32'(bus.in_ready), 32'h7);
    check("abort_no_out", 32'(bus.out_valid), 32'h0);
    cycle(3'b010, 6'b000000, 1'b0, 1'b0);
    cycle(3'b010, 6'b000100, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0);
    check("abort_next_data", 32'(bus.out_data), 32'h4);
    check("abort_next_ch", 32'(bus.out_ch), 32'h1);
    idle(2);

    // Contention: all three channels complete together.
    cycle('0, '0, 1'b1, 1'b0);
    cycle(3'b111, 6'b111001, 1'b0, 1'b0);
    cycle(3'b111, 6'b000110, 1'b0, 1'b0);
    check("bug_set", 32'(bug), 32'h1);
    cycle('0, '0, 1'b0, 1'b0);
    check("bug_clear", 32'(bug), 32'h0);
    check("cont0_ch", 32'(bus.out_ch), 32'h0);
    check("cont0_data", 32'(bus.out_data), 32'h9);
    cycle('0, '0, 1'b0, 1'b0);
    check("cont1_valid", 32'(bus.out_valid), 32'h1);
    check("cont1_ch", 32'(bus.out_ch), 32'h1);
    check("cont1_data", 32'(bus.out_data), 32'h6);
    cycle('0, '0, 1'b0, 1'b0);
    check("cont2_ch", 32'(bus.out_ch), 32'h2);
    check("cont2_data", 32'(bus.out_data), 32'h3);
    cycle('0, '0, 1'b0, 1'b0);
    check("cont_done", 32'(bus.out_valid), 32'h0);

    // Round-robin after ch2 grant: ch0 before ch2.
    cycle(3'b101, 6'b010010, 1'b0, 1'b0);
    cycle(3'b101, 6'b110011, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0);
    check("rr_first_ch", 32'(bus.out_ch), 32'h0);
    check("rr_first_data", 32'(bus.out_data), 32'he);
    cycle('0, '0, 1'b0, 1'b0);
    check("rr_second_ch", 32'(bus.out_ch), 32'h2);
    check("rr_second_data", 32'(bus.out_data), 32'hd);
    idle(2);

    // Reset mid-RECV discards the partial word.
    cycle(3'b001, 6'b000001, 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    check("midrst_ready", 32'(bus.in_ready), 32'h7);
    for (int i = 0; i < 3; i++) begin
      cycle('0, '0, 1'b0, 1'b0);
      check("midrst_no_out", 32'(bus.out_valid), 32'h0);
    end

    // meta_reset clears coverage, then idle vector counts again.
    cycle('0, '0, 1'b0, 1'b1);
    check("meta_zero", 32'(coverage), 32'd0);
    cycle('0, '0, 1'b0, 1'b0);
    check("meta_one", 32'(coverage), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) rv[c] = ($urandom_range(0, 3) != 0);
      rd = NCH*BEAT_W'($urandom);
      rr = ($urandom_range(0, 99) == 0);
      rm = ($urandom_range(0, 149) == 0);
      cycle(rv, rd, rr, rm);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
